// File: rtl/dense_update_w_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dense_update_w_pkg                                               |
// | Shared dimensions, fixed-point formats and FSM states.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dense_update_w_pkg;

  localparam int N        = 4;   // batch size
  localparam int HID_DIM  = 8;   // rows of W
  localparam int CHAR_NUM = 8;   // columns of W
  localparam int DATA_N   = 4;   // weights per RAM word
  localparam int N_LEN    = 16;  // weight / layer-input width
  localparam int N_LEN_W  = 16;  // output-gradient width
  localparam int FRAC     = 4;   // fractional bits of x
  localparam int FRAC_W   = 4;   // fractional bits of d

  localparam int GRAD_SHIFT_DEFAULT = FRAC + FRAC_W;

  localparam int WORDS = HID_DIM * CHAR_NUM / DATA_N;
  localparam int H_W   = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int C_W   = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dense_update_w_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dense_update_w_lane                                              |
// | One weight lane: N-term MAC, floor shift, subtract, saturate.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dense_update_w_lane
  import dense_update_w_pkg::*;
#(
  parameter int GRAD_SHIFT = GRAD_SHIFT_DEFAULT
) (
  input  logic [N*N_LEN-1:0]   xs,
  input  logic [N*N_LEN_W-1:0] ds,
  input  logic [N_LEN-1:0]     w_old,
  output logic [N_LEN-1:0]     w_new
);

  localparam int PROD_W = N_LEN + N_LEN_W;
  localparam int SUM_W  = PROD_W + ((N > 1) ? $clog2(N) : 0);
  localparam int DIFF_W = SUM_W + 1;

  localparam logic signed [DIFF_W-1:0] MAX_V = {{(DIFF_W-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] MIN_V = ~MAX_V;

  logic signed [N_LEN-1:0]   w_xs   [N];
  logic signed [N_LEN_W-1:0] w_ds   [N];
  logic signed [PROD_W-1:0]  w_prod [N];
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [SUM_W-1:0]   w_delta;
  logic signed [N_LEN-1:0]   w_old_s;
  logic signed [DIFF_W-1:0]  w_diff;

  always_comb begin
    w_sum = '0;
    for (int n = 0; n < N; n++) begin
      w_xs[n]   = xs[n*N_LEN +: N_LEN];
      w_ds[n]   = ds[n*N_LEN_W +: N_LEN_W];
      w_prod[n] = PROD_W'(w_xs[n]) * PROD_W'(w_ds[n]);
      w_sum     = w_sum + SUM_W'(w_prod[n]);
    end
  end

  // Arithmetic shift floors toward -inf, which is the intended rounding.
  assign w_delta = w_sum >>> GRAD_SHIFT;
  assign w_old_s = w_old;
  assign w_diff  = DIFF_W'(w_old_s) - DIFF_W'(w_delta);

  always_comb begin
    w_new = w_diff[N_LEN-1:0];
    if (w_diff > MAX_V)
      w_new = {1'b0, {(N_LEN-1){1'b1}}};
    else if (w_diff < MIN_V)
      w_new = {1'b1, {(N_LEN-1){1'b0}}};
  end

endmodule
`default_nettype wire

// File: rtl/dense_update_w.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dense_update_w                                                   |
// | Read-modify-write pass applying W -= (x^T d) >>> GRAD_SHIFT.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dense_update_w
  import dense_update_w_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int GRAD_SHIFT = GRAD_SHIFT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [N*HID_DIM*N_LEN-1:0]    x,
  input  logic [N*CHAR_NUM*N_LEN_W-1:0] d,
  output logic                          valid,
  output logic [ADDR_WIDTH-1:0]         raddr,
  input  logic [DATA_N*N_LEN-1:0]       rdata,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [DATA_N*N_LEN-1:0]       wdata,
  output logic                          we
);

  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(WORDS - 1);
  localparam logic [C_W-1:0]        C0_LAST = C_W'(CHAR_NUM - DATA_N);

  state_t                    r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_rd_idx;   // address whose data is on rdata now
  logic [H_W-1:0]            r_h;
  logic [C_W-1:0]            r_c0;
  logic                      w_wr_go;
  logic                      w_advance;
  logic [N*N_LEN-1:0]        w_x_col;
  logic [N*N_LEN_W-1:0]      w_d_sel [DATA_N];
  logic [DATA_N*N_LEN-1:0]   w_new_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_go     = 1'b0;
    w_advance   = 1'b0;
    if (!run) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_READ;
        S_READ: begin
          w_wr_go   = 1'b1;
          w_advance = 1'b1;
          if (raddr == LAST_A) w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          w_wr_go     = 1'b1;
          w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr    <= '0;
      r_rd_idx <= '0;
      r_h      <= '0;
      r_c0     <= '0;
      waddr    <= '0;
      wdata    <= '0;
      we       <= 1'b0;
      valid    <= 1'b0;
    end else if (!run) begin
      raddr    <= '0;
      r_rd_idx <= '0;
      r_h      <= '0;
      r_c0     <= '0;
      waddr    <= '0;
      wdata    <= '0;
      we       <= 1'b0;
      valid    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE || r_state == S_READ) && raddr != LAST_A)
        raddr <= raddr + ADDR_WIDTH'(1);
      if (w_advance) begin
        r_rd_idx <= r_rd_idx + ADDR_WIDTH'(1);
        if (r_c0 == C0_LAST) begin
          r_c0 <= '0;
          r_h  <= r_h + H_W'(1);
        end else begin
          r_c0 <= r_c0 + C_W'(DATA_N);
        end
      end
      we <= w_wr_go;
      if (w_wr_go) begin
        waddr <= r_rd_idx;
        wdata <= w_new_word;
      end
      valid <= (r_state == S_DONE);
    end
  end

  // Operand selection: column h of x and columns c0..c0+DATA_N-1 of d.
  always_comb begin
    w_x_col = '0;
    for (int n = 0; n < N; n++)
      w_x_col[n*N_LEN +: N_LEN] = x[(n*HID_DIM + int'(r_h))*N_LEN +: N_LEN];
  end

  always_comb begin
    for (int k = 0; k < DATA_N; k++) begin
      w_d_sel[k] = '0;
      for (int n = 0; n < N; n++)
        w_d_sel[k][n*N_LEN_W +: N_LEN_W] =
          d[(n*CHAR_NUM + int'(r_c0) + k)*N_LEN_W +: N_LEN_W];
    end
  end

  generate
    for (genvar k = 0; k < DATA_N; k++) begin : g_lane
      dense_update_w_lane #(
        .GRAD_SHIFT (GRAD_SHIFT)
      ) u_lane (
        .xs    (w_x_col),
        .ds    (w_d_sel[k]),
        .w_old (rdata[k*N_LEN +: N_LEN]),
        .w_new (w_new_word[k*N_LEN +: N_LEN])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dense_update_w.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dense_update_w                                                |
// | Bench with a RAM model and a plain-arithmetic weight model.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dense_update_w;
  import dense_update_w_pkg::*;

  localparam int AW   = 10;
  localparam int GS   = 8;
  localparam int NF   = HID_DIM * CHAR_NUM;
  localparam int LAST = WORDS - 1;
  localparam int WMAX = (1 << (N_LEN - 1)) - 1;
  localparam int WMIN = -(1 << (N_LEN - 1));

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          run;
  logic [N*HID_DIM*N_LEN-1:0]    x;
  logic [N*CHAR_NUM*N_LEN_W-1:0] d;
  logic                          valid;
  logic [AW-1:0]                 raddr;
  logic [DATA_N*N_LEN-1:0]       rdata;
  logic [AW-1:0]                 waddr;
  logic [DATA_N*N_LEN-1:0]       wdata;
  logic                          we;

  dense_update_w #(.ADDR_WIDTH(AW), .GRAD_SHIFT(GS)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .x(x), .d(d), .valid(valid),
    .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata), .we(we)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: synchronous read, synchronous write, bulk load port.
  logic [DATA_N*N_LEN-1:0] mem      [WORDS];
  logic [DATA_N*N_LEN-1:0] load_img [WORDS];
  logic                    load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) mem <= load_img;
    else if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  int total = 0;
  int bad   = 0;
  int x_v [N][HID_DIM];
  int d_v [N][CHAR_NUM];
  int wm  [NF];
  int orig[NF];

  typedef struct {
    int h; int c; int xv; int dv; int w0; int wexp;
  } pt_vec_t;
  pt_vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_val(input int f);
    logic signed [N_LEN-1:0] t;
    t = mem[f / DATA_N][(f % DATA_N)*N_LEN +: N_LEN];
    return int'(t);
  endfunction

  function automatic int rnd_range(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  function automatic longint floor_div(input longint s, input longint q);
    longint r;
    r = s / q;
    if ((s % q) != 0 && s < 0) r = r - 1;
    return r;
  endfunction

  task automatic mem_check(input string name);
    int nbad;
    int first;
    nbad = 0;
    first = 0;
    for (int f = 0; f < NF; f++)
      if (lane_val(f) != wm[f]) begin
        if (nbad == 0) first = f;
        nbad++;
      end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s: %0d weights differ, idx %0d got %0d expected %0d",
               name, nbad, first, lane_val(first), wm[first]);
    end
  endtask

  // Reference: W[h][c] -= floor(sum_n x[n][h]*d[n][c] / 2^GS), clamped.
  task automatic model_pass(input int upto_word);
    longint s;
    longint v;
    for (int f = 0; f < NF; f++) begin
      if (f / DATA_N < upto_word) begin
        s = 0;
        for (int n = 0; n < N; n++)
          s += longint'(x_v[n][f / CHAR_NUM]) * longint'(d_v[n][f % CHAR_NUM]);
        v = longint'(wm[f]) - floor_div(s, longint'(1) << GS);
        if (v > WMAX) v = WMAX;
        if (v < WMIN) v = WMIN;
        wm[f] = int'(v);
      end
    end
  endtask

  task automatic clear_xd();
    for (int n = 0; n < N; n++) begin
      for (int h = 0; h < HID_DIM; h++) x_v[n][h] = 0;
      for (int c = 0; c < CHAR_NUM; c++) d_v[n][c] = 0;
    end
  endtask

  task automatic apply_xd();
    for (int n = 0; n < N; n++) begin
      for (int h = 0; h < HID_DIM; h++)
        x[(n*HID_DIM + h)*N_LEN +: N_LEN] = N_LEN'(x_v[n][h]);
      for (int c = 0; c < CHAR_NUM; c++)
        d[(n*CHAR_NUM + c)*N_LEN_W +: N_LEN_W] = N_LEN_W'(d_v[n][c]);
    end
  endtask

  task automatic load_mem();
    for (int f = 0; f < NF; f++) begin
      load_img[f / DATA_N][(f % DATA_N)*N_LEN +: N_LEN] = N_LEN'(wm[f]);
      orig[f] = wm[f];
    end
    @(negedge clk) load_en = 1'b1;
    @(negedge clk) load_en = 1'b0;
    @(negedge clk);
  endtask

  // Raises run before edge 0, observes LAST+8 edges; drops run after edge drop_at.
  task automatic run_pass(input int drop_at, output int we_cnt, output int first_we,
                          output int valid_edge, output int order_bad);
    int exp_addr;
    exp_addr = 0; we_cnt = 0; first_we = -1; valid_edge = -1; order_bad = 0;
    @(negedge clk) run = 1'b1;
    for (int e = 0; e < LAST + 8; e++) begin
      @(posedge clk); #1;
      if (we) begin
        if (int'(waddr) != exp_addr) order_bad++;
        if (first_we < 0) first_we = e;
        exp_addr++;
        we_cnt++;
      end
      if (valid && valid_edge < 0) valid_edge = e;
      if (e == drop_at) run = 1'b0;
    end
  endtask

  task automatic end_pass(input string name);
    @(negedge clk) run = 1'b0;
    @(posedge clk); #1;
    check(name, {valid, we, (raddr == '0), (waddr == '0), (wdata == '0)}, 5'b00111);
  endtask

  task automatic full_pass(input string name, input bit check_timing);
    int wc, fw, ve, ob;
    run_pass(-1, wc, fw, ve, ob);
    if (check_timing) begin
      check({name, "_we_count"}, wc, LAST + 1);
      check({name, "_first_we_edge"}, fw, 1);
      check({name, "_valid_edge"}, ve, LAST + 2);
      check({name, "_addr_order"}, ob, 0);
      check({name, "_valid_held"}, valid, 1);
    end
    end_pass({name, "_idle"});
  endtask

  initial begin
    int wc, fw, ve, ob, nb;

    // h, c, x[0][h], d[0][c], initial W[h][c], expected W[h][c]
    vecs[0] = '{3, 5,    256,   -256,    100,    356};
    vecs[1] = '{0, 0,   1000,  -2000,  32767,  32767};
    vecs[2] = '{7, 7,   1000,   2000, -32768, -32768};
    vecs[3] = '{2, 6,     -3,      5,      0,      1};
    vecs[4] = '{1, 1,      3,      5,      0,      0};
    vecs[5] = '{5, 2, -32768, -32768, -32768, -32768};
    vecs[6] = '{6, 3, -32768,  32767,  32767,  32767};
    vecs[7] = '{4, 0,    512,    128,   -100,   -356};

    rst_n = 1'b0; run = 1'b0; x = '0; d = '0;
    for (int a = 0; a < WORDS; a++) mem[a] = '0;
    #12;
    check("reset_outputs", {valid, we, (raddr == '0), (waddr == '0), (wdata == '0)}, 5'b00111);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {valid, we, (raddr == '0)}, 3'b001);

    // x = 0: no weight may change.
    clear_xd();
    for (int n = 0; n < N; n++)
      for (int c = 0; c < CHAR_NUM; c++) d_v[n][c] = rnd_range(-30000, 30000);
    for (int f = 0; f < NF; f++) wm[f] = rnd_range(WMIN, WMAX);
    apply_xd(); load_mem();
    full_pass("zero_x", 1'b1);
    mem_check("zero_x_mem");

    // Unit operands: every weight drops by exactly N.
    for (int n = 0; n < N; n++) begin
      for (int h = 0; h < HID_DIM; h++) x_v[n][h] = 1 << FRAC;
      for (int c = 0; c < CHAR_NUM; c++) d_v[n][c] = 1 << FRAC_W;
    end
    for (int f = 0; f < NF; f++) wm[f] = rnd_range(-30000, 30000);
    apply_xd(); load_mem();
    full_pass("unit", 1'b0);
    for (int f = 0; f < NF; f++) wm[f] = orig[f] - N;
    mem_check("unit_minus_n");

    // Single-entry table: target changes to the listed value, rest untouched.
    foreach (vecs[i]) begin
      clear_xd();
      x_v[0][vecs[i].h] = vecs[i].xv;
      d_v[0][vecs[i].c] = vecs[i].dv;
      for (int f = 0; f < NF; f++) wm[f] = rnd_range(WMIN, WMAX);
      wm[vecs[i].h*CHAR_NUM + vecs[i].c] = vecs[i].w0;
      apply_xd(); load_mem();
      full_pass($sformatf("pt%0d", i), i == 0);
      check($sformatf("pt%0d_target", i), lane_val(vecs[i].h*CHAR_NUM + vecs[i].c), vecs[i].wexp);
      nb = 0;
      for (int f = 0; f < NF; f++)
        if (f != vecs[i].h*CHAR_NUM + vecs[i].c && lane_val(f) != orig[f]) nb++;
      check($sformatf("pt%0d_others", i), nb, 0);
    end

    // Random batches against the reference model.
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < N; n++) begin
        for (int h = 0; h < HID_DIM; h++)
          x_v[n][h] = (p == 3) ? rnd_range(WMIN, WMAX) : rnd_range(-200, 200);
        for (int c = 0; c < CHAR_NUM; c++)
          d_v[n][c] = (p == 3) ? rnd_range(WMIN, WMAX) : rnd_range(-200, 200);
      end
      for (int f = 0; f < NF; f++) wm[f] = rnd_range(WMIN, WMAX);
      apply_xd(); load_mem();
      full_pass($sformatf("rand%0d", p), 1'b0);
      model_pass(WORDS);
      mem_check($sformatf("rand%0d_mem", p));
    end

    // run dropped after edge 5: addresses 0..4 written, nothing else, no valid.
    for (int n = 0; n < N; n++) begin
      for (int h = 0; h < HID_DIM; h++) x_v[n][h] = rnd_range(-200, 200);
      for (int c = 0; c < CHAR_NUM; c++) d_v[n][c] = rnd_range(-200, 200);
    end
    for (int f = 0; f < NF; f++) wm[f] = rnd_range(-20000, 20000);
    apply_xd(); load_mem();
    run_pass(5, wc, fw, ve, ob);
    check("drop_we_count", wc, 5);
    check("drop_valid_edge", ve, -1);
    check("drop_addr_order", ob, 0);
    model_pass(5);
    mem_check("drop_partial_mem");
    full_pass("rerun", 1'b1);
    model_pass(WORDS);
    mem_check("rerun_mem");

    // Asynchronous reset in the middle of READ.
    for (int f = 0; f < NF; f++) wm[f] = rnd_range(-20000, 20000);
    load_mem();
    @(negedge clk) run = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {valid, we, (raddr == '0), (waddr == '0), (wdata == '0)}, 5'b00111);
    run = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_pass(4);
    @(negedge clk);
    mem_check("async_reset_partial_mem");
    full_pass("after_reset", 1'b1);
    model_pass(WORDS);
    mem_check("after_reset_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
